// File: rtl/packed_rec_fifo_if.sv
`default_nettype none
// ============================================================================
// Module  : packed_rec_fifo_if
// Brief   : Write/read handshake bundle for packed_rec_fifo.
// Revision: 1.0  initial release
// ============================================================================
interface packed_rec_fifo_if #(
    parameter int DATA_W = 8,
    parameter int TAG_W  = 4,
    parameter int DEPTH  = 4
);
    logic                       i_valid;
    logic                       o_ready;
    logic [TAG_W+DATA_W-1:0]    i_rec;
    logic                       o_valid;
    logic                       i_ready;
    logic [DATA_W-1:0]          o_a;
    logic [TAG_W-1:0]           o_tag;
    logic [$clog2(DEPTH):0]     o_count;
    logic                       o_ovf;

    // FIFO side
    modport slave (
        input  i_valid, i_rec, i_ready,
        output o_ready, o_valid, o_a, o_tag, o_count, o_ovf
    );

    // Producer/consumer side
    modport master (
        output i_valid, i_rec, i_ready,
        input  o_ready, o_valid, o_a, o_tag, o_count, o_ovf
    );
endinterface
`default_nettype wire

// File: rtl/packed_rec_fifo.sv
`default_nettype none
// ============================================================================
// Module  : packed_rec_fifo
// Brief   : Synchronous FIFO of {tag, data} records, sticky overflow flag.
// Revision: 1.0  initial release
// ============================================================================
module packed_rec_fifo #(
    parameter int                DATA_W    = 8,
    parameter int                TAG_W     = 4,
    parameter int                DEPTH     = 4,
    parameter logic [DATA_W-1:0] FILL_DATA = '1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    packed_rec_fifo_if.slave   bus
);
    localparam int               PTR_W  = $clog2(DEPTH);
    localparam int               CNT_W  = PTR_W + 1;
    localparam int               REC_W  = TAG_W + DATA_W;
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] C_STEP = PTR_W'(1);

    logic [REC_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;

    logic             w_ready;
    logic             w_valid;
    logic             w_wr;
    logic             w_rd;
    logic [REC_W-1:0] w_head;

    assign w_ready = (r_count != C_FULL);
    assign w_valid = (r_count != '0);
    // Acceptance is judged on pre-edge state, so a full FIFO refuses a write
    // even when a read frees a slot on the same edge.
    assign w_wr    = bus.i_valid & w_ready;
    assign w_rd    = bus.i_ready & w_valid;
    assign w_head  = r_mem[r_rd_ptr];

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!rst && w_wr) begin
            r_mem[r_wr_ptr] <= bus.i_rec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + C_STEP;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + C_STEP;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + C_ONE;
                2'b01:   r_count <= r_count - C_ONE;
                default: r_count <= r_count;
            endcase
            if (bus.i_valid && !w_ready) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign bus.o_ready = w_ready;
    assign bus.o_valid = w_valid;
    assign bus.o_count = r_count;
    assign bus.o_ovf   = r_ovf;
    assign bus.o_a     = w_valid ? w_head[DATA_W-1:0]     : FILL_DATA;
    assign bus.o_tag   = w_valid ? w_head[REC_W-1:DATA_W] : '0;
endmodule
`default_nettype wire
